// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/c_muldiv_shift_core.sv
// Radix-2 iterative datapath: shift-add multiply and, with MULDIV_DIV_EN,
// restoring shift-subtract divide on unsigned magnitudes. acc holds {hi, lo}.
module c_muldiv_shift_core #(
  parameter int unsigned XLEN = muldiv_pkg::XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   mag_a_i,
  input  logic [XLEN-1:0]   mag_b_i,
  output logic              cnt_zero_o,
  output logic [2*XLEN-1:0] acc_o
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned AW = 2 * XLEN;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN:0]   mul_sum_c;
`ifdef MULDIV_DIV_EN
  logic            div_ge_c;
  logic [XLEN-1:0] div_rem_c;
`endif

  // Next-state for counter, accumulator and latched divisor/multiplicand
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    mul_sum_c = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
`ifdef MULDIV_DIV_EN
    // Trial value is the partial remainder shifted left with the next dividend bit
    div_ge_c  = acc_q[AW-1:XLEN-1] >= {1'b0, b_q};
    div_rem_c = acc_q[AW-2:XLEN-1] - b_q;
`endif
    if (load_i) begin
      acc_d = {{XLEN{1'b0}}, mag_a_i};
      b_d   = mag_b_i;
      cnt_d = CW'(XLEN - 1);
    end else if (step_i) begin
      cnt_d = cnt_q - CW'(1);
`ifdef MULDIV_DIV_EN
      if (is_div_i) begin
        if (div_ge_c) acc_d = {div_rem_c, acc_q[XLEN-2:0], 1'b1};
        else          acc_d = {acc_q[AW-2:0], 1'b0};
      end else begin
        acc_d = {mul_sum_c, acc_q[XLEN-1:1]};
      end
`else
      if (!is_div_i) acc_d = {mul_sum_c, acc_q[XLEN-1:1]};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      acc_q <= '0;
      b_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      b_q   <= b_d;
    end
  end

  assign cnt_zero_o = (cnt_q == '0);
  assign acc_o      = acc_q;

endmodule

// File: rtl/c_ex_muldiv_unit.sv
// EX-stage RV32M unit: FSM, operand sign handling and result fix-up.
// Define MULDIV_DIV_EN to build the divide/remainder datapath.
module c_ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3_E,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            FlushE,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned AW = 2 * XLEN;

  state_e          state_q, state_d;
  logic [2:0]      f3_q;
  logic            neg_a_q, neg_b_q;
  logic            neg_a_c, neg_b_c, sign_a_c, sign_b_c;
  logic [XLEN-1:0] mag_a_c, mag_b_c;
  logic            fast_c, load_c, step_c, cnt_zero_c;
  logic [AW-1:0]   acc_c, acc_neg_c;
  logic [XLEN-1:0] acc_hi_c, acc_lo_c;
`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0] op_a_q;
  logic            div0_q, ovf_q, div0_c, ovf_c;
`endif

  // Operand decode: signedness, magnitudes and the no-iteration cases
  always_comb begin
    sign_a_c = (funct3_E == F3_MULH) || (funct3_E == F3_MULHSU) ||
               (funct3_E == F3_DIV)  || (funct3_E == F3_REM);
    sign_b_c = (funct3_E == F3_MULH) || (funct3_E == F3_DIV) || (funct3_E == F3_REM);
    neg_a_c  = sign_a_c & op_a[XLEN-1];
    neg_b_c  = sign_b_c & op_b[XLEN-1];
    mag_a_c  = neg_a_c ? '0 - op_a : op_a;
    mag_b_c  = neg_b_c ? '0 - op_b : op_b;
`ifdef MULDIV_DIV_EN
    div0_c   = (op_b == '0);
    ovf_c    = ~funct3_E[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b);
    fast_c   = funct3_E[2] & (div0_c | ovf_c);
`else
    fast_c   = funct3_E[2];
`endif
  end

  // FSM next-state and control outputs
  always_comb begin
    state_d   = state_q;
    load_c    = 1'b0;
    step_c    = 1'b0;
    stall_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !FlushE) begin
          load_c    = 1'b1;
          stall_req = 1'b1;
          state_d   = fast_c ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall_req = 1'b1;
        if (FlushE) begin
          state_d = IDLE;
        end else begin
          step_c = 1'b1;
          if (cnt_zero_c) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      f3_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      op_a_q  <= '0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (load_c) begin
        f3_q    <= funct3_E;
        neg_a_q <= neg_a_c;
        neg_b_q <= neg_b_c;
`ifdef MULDIV_DIV_EN
        op_a_q  <= op_a;
        div0_q  <= div0_c;
        ovf_q   <= ovf_c;
`endif
      end
    end
  end

  c_muldiv_shift_core #(.XLEN(XLEN)) u_core (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_c),
    .step_i     (step_c),
    .is_div_i   (f3_q[2]),
    .mag_a_i    (mag_a_c),
    .mag_b_i    (mag_b_c),
    .cnt_zero_o (cnt_zero_c),
    .acc_o      (acc_c)
  );

  // Result select with sign fix-up; zero outside DONE
  always_comb begin
    acc_hi_c  = acc_c[AW-1:XLEN];
    acc_lo_c  = acc_c[XLEN-1:0];
    acc_neg_c = '0 - acc_c;
    result    = '0;
    if (state_q == DONE) begin
      case (f3_q)
        F3_MUL:            result = acc_lo_c;
        F3_MULH, F3_MULHSU: result = (neg_a_q ^ neg_b_q) ? acc_neg_c[AW-1:XLEN] : acc_hi_c;
        F3_MULHU:          result = acc_hi_c;
`ifdef MULDIV_DIV_EN
        F3_DIV, F3_DIVU: begin
          if (div0_q)     result = '1;
          else if (ovf_q) result = op_a_q;
          else            result = (neg_a_q ^ neg_b_q) ? '0 - acc_lo_c : acc_lo_c;
        end
        F3_REM, F3_REMU: begin
          if (div0_q)     result = op_a_q;
          else if (ovf_q) result = '0;
          else            result = neg_a_q ? '0 - acc_hi_c : acc_hi_c;
        end
`endif
        default:           result = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_c_ex_muldiv_unit.sv
// Directed-vector bench for c_ex_muldiv_unit (expects div results only when
// MULDIV_DIV_EN is defined; otherwise 1xx ops return 0 after one cycle).
module tb_c_ex_muldiv_unit;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            reset;
  logic            start;
  logic [2:0]      funct3_E;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            FlushE;
  logic            stall_req;
  logic            done;
  logic [XLEN-1:0] result;
  logic            busy;

  c_ex_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .funct3_E  (funct3_E),
    .op_a      (op_a),
    .op_b      (op_b),
    .FlushE    (FlushE),
    .stall_req (stall_req),
    .done      (done),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int zero_viol = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // result must read zero whenever done is low
  always @(negedge clk) begin
    if (reset === 1'b1 && done !== 1'b1 && result !== '0) zero_viol++;
  end

  // Issue one op in cycle 0, return result, done cycle, and BUSY stall count
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int stalls,
                        output logic st0, output logic dstall);
    @(negedge clk);
    funct3_E = f3; op_a = a; op_b = b; start = 1'b1;
    #1 st0 = stall_req;
    @(negedge clk);
    start = 1'b0;
    lat = 1; stalls = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (stall_req === 1'b1) stalls++;
      @(negedge clk);
      lat++;
    end
    res = result;
    dstall = stall_req;
  endtask

  logic [31:0] r, exp_r;
  int          lat, stl, exp_lat, ndone, first_d, second_d;
  logic        s0, ds;

  initial begin
    vecs[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[4]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[5]  = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 33};
    vecs[6]  = '{3'b011, 32'h80000000, 32'h00000002, 32'h00000001, 33};
    vecs[7]  = '{3'b000, 32'h00000000, 32'h00012345, 32'h00000000, 33};
    vecs[8]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
    vecs[9]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
    vecs[10] = '{3'b101, 32'h00000064, 32'h00000000, 32'hFFFFFFFF, 1};
    vecs[11] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[12] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[13] = '{3'b101, 32'h00000064, 32'h00000007, 32'h0000000E, 33};
    vecs[14] = '{3'b111, 32'h00000064, 32'h00000007, 32'h00000002, 33};
    vecs[15] = '{3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[16] = '{3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[17] = '{3'b111, 32'h00000064, 32'h00000000, 32'h00000064, 1};
    vecs[18] = '{3'b110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1};
    vecs[19] = '{3'b101, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 33};
    vecs[20] = '{3'b010, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 33};
    vecs[21] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33};
    vecs[22] = '{3'b100, 32'h80000000, 32'h00000001, 32'h80000000, 33};
    vecs[23] = '{3'b100, 32'h80000000, 32'hFFFFFFFE, 32'h40000000, 33};

    reset = 1'b0; start = 1'b0; FlushE = 1'b0;
    funct3_E = 3'b000; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_stall", 32'(stall_req), 32'd0);
    chk("reset_done",  32'(done),      32'd0);
    chk("reset_busy",  32'(busy),      32'd0);
    chk("reset_result", result,        32'd0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      exp_r   = vecs[i].exp;
      exp_lat = vecs[i].lat;
`ifndef MULDIV_DIV_EN
      if (vecs[i].f3[2]) begin
        exp_r   = '0;
        exp_lat = 1;
      end
`endif
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, r, lat, stl, s0, ds);
      chk($sformatf("v%0d_result", i),  r, exp_r);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat));
      chk($sformatf("v%0d_busy_stalls", i), 32'(stl), (exp_lat == 33) ? 32'd32 : 32'd0);
      chk($sformatf("v%0d_start_stall", i), 32'(s0), 32'd1);
      chk($sformatf("v%0d_done_stall", i),  32'(ds), 32'd0);
    end

    // Flush in BUSY cycle 10 abandons the op; a following op completes
    @(negedge clk);
    funct3_E = 3'b000; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_busy_before", 32'(busy), 32'd1);
    FlushE = 1'b1;
    @(negedge clk);
    FlushE = 1'b0;
    chk("flush_busy_after",  32'(busy),      32'd0);
    chk("flush_done_after",  32'(done),      32'd0);
    chk("flush_stall_after", 32'(stall_req), 32'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("flush_no_done", 32'(ndone), 32'd0);
    run_op(3'b000, 32'd3, 32'd5, r, lat, stl, s0, ds);
    chk("post_flush_result",  r,         32'd15);
    chk("post_flush_latency", 32'(lat),  32'd33);

    // FlushE wins over start in IDLE
    @(negedge clk);
    funct3_E = 3'b000; op_a = 32'd2; op_b = 32'd2; start = 1'b1; FlushE = 1'b1;
    #1 chk("flush_prio_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    start = 1'b0; FlushE = 1'b0;
    chk("flush_prio_busy", 32'(busy), 32'd0);

    // Reset in BUSY cycle 5 clears everything with no done pulse
    @(negedge clk);
    funct3_E = 3'b011; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_stall",  32'(stall_req), 32'd0);
    chk("rst_mid_done",   32'(done),      32'd0);
    chk("rst_mid_busy",   32'(busy),      32'd0);
    chk("rst_mid_result", result,         32'd0);
    reset = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("rst_mid_no_done", 32'(ndone), 32'd0);

    // Start held high: one done per accepted start, no retrigger from DONE
    @(negedge clk);
    funct3_E = 3'b000; op_a = 32'd2; op_b = 32'd3; start = 1'b1;
    ndone = 0; first_d = -1; second_d = -1;
    for (int c = 0; c < 68; c++) begin
      #1;
      if (done === 1'b1) begin
        ndone++;
        if (first_d < 0) first_d = c; else second_d = c;
        chk($sformatf("held_result_c%0d", c), result, 32'd6);
        chk($sformatf("held_stall_c%0d", c),  32'(stall_req), 32'd0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("held_done_count",  32'(ndone),    32'd2);
    chk("held_first_done",  32'(first_d),  32'd33);
    chk("held_second_done", 32'(second_d), 32'd67);
    repeat (40) @(negedge clk);

    chk("result_zero_when_not_done", 32'(zero_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
